// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display pixel fetch has priority, CPU load/store is
// protected from starvation by a bounded-wait override. Read data returns one cycle after grant.
module vram_arbiter #(
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rd_valid,
    output logic [DATA_W-1:0] disp_rd_data,
    input  logic              cpu_valid,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [CNT_W-1:0]  conflict_count
);

    localparam int unsigned SW = $clog2(MAX_WAIT + 1) + 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    owner_e          rd_owner;
    owner_e          rd_owner_nxt;
    logic [SW-1:0]   starve_cnt;
    logic [SW-1:0]   starve_nxt;
    logic [CNT_W-1:0] conflict_nxt;
    logic            starve_hit;
    logic            disp_win;
    logic            cpu_win;
    mem_req_t        mem_req;

    // MAX_WAIT of zero means a valid CPU request always overrides the display
    generate
        if (MAX_WAIT == 0) begin : g_cpu_first
            assign starve_hit = 1'b1;
        end else begin : g_bounded
            assign starve_hit = (starve_cnt >= SW'(MAX_WAIT));
        end
    endgenerate

    // Winner selection; depends only on requests and registered wait state
    always_comb begin
        disp_win = 1'b0;
        cpu_win  = 1'b0;
        if (cpu_valid && starve_hit) begin
            cpu_win = 1'b1;
        end else if (disp_req) begin
            disp_win = 1'b1;
        end else if (cpu_valid) begin
            cpu_win = 1'b1;
        end
    end

    assign disp_gnt  = disp_win;
    assign cpu_ready = cpu_win;

    // Memory request mux; idle cycles drive zeros
    always_comb begin
        mem_req = '0;
        if (disp_win) begin
            mem_req.addr = disp_addr;
        end else if (cpu_win) begin
            mem_req.addr  = cpu_addr;
            mem_req.we    = cpu_we;
            mem_req.wdata = cpu_wdata;
        end
    end

    assign mem_addr  = mem_req.addr;
    assign mem_we    = mem_req.we;
    assign mem_wdata = mem_req.wdata;

    // Next-state for return tag, starvation counter and conflict counter
    always_comb begin
        rd_owner_nxt = OWN_NONE;
        starve_nxt   = starve_cnt;
        conflict_nxt = conflict_count;

        if (disp_win) begin
            rd_owner_nxt = OWN_DISP;
        end else if (cpu_win && !cpu_we) begin
            rd_owner_nxt = OWN_CPU;
        end

        if (!cpu_valid || cpu_win) begin
            starve_nxt = '0;
        end else if (!starve_hit) begin
            starve_nxt = starve_cnt + SW'(1);
        end

        if (disp_req && cpu_valid && (conflict_count != {CNT_W{1'b1}})) begin
            conflict_nxt = conflict_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_owner       <= OWN_NONE;
            starve_cnt     <= '0;
            conflict_count <= '0;
        end else begin
            rd_owner       <= rd_owner_nxt;
            starve_cnt     <= starve_nxt;
            conflict_count <= conflict_nxt;
        end
    end

    // Read returns are decoded straight from the tag so reset kills them immediately
    assign disp_rd_valid = (rd_owner == OWN_DISP);
    assign cpu_rvalid    = (rd_owner == OWN_CPU);
    assign disp_rd_data  = mem_rd_data;
    assign cpu_rdata     = mem_rd_data;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: table-driven cycle vectors on the default
// configuration, plus hand sequences for MAX_WAIT=0, reset mid-read and counter saturation.
module tb_vram_arbiter;

    localparam int unsigned AW = 17;
    localparam int unsigned DW = 8;

    logic clk;
    logic rstb;
    logic disp_req;
    logic [AW-1:0] disp_addr;
    logic cpu_valid;
    logic cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;

    // default instance (MAX_WAIT=4, CNT_W=16)
    logic disp_gnt, disp_rd_valid, cpu_ready, cpu_rvalid, mem_we;
    logic [DW-1:0] disp_rd_data, cpu_rdata, mem_wdata, mem_q;
    logic [AW-1:0] mem_addr;
    logic [15:0] conflict_count;

    // MAX_WAIT=0 instance
    logic d0_gnt, d0_rvalid_d, d0_ready, d0_rvalid_c, d0_we;
    logic [DW-1:0] d0_drdata, d0_crdata, d0_wdata;
    logic [AW-1:0] d0_addr;
    logic [15:0] d0_cc;

    // CNT_W=4 instance
    logic ds_gnt, ds_rvalid_d, ds_ready, ds_rvalid_c, ds_we;
    logic [DW-1:0] ds_drdata, ds_crdata, ds_wdata;
    logic [AW-1:0] ds_addr;
    logic [3:0] ds_cc;

    logic [DW-1:0] zero_rd;
    assign zero_rd = '0;

    int errors;
    int checks;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4), .CNT_W(16)) dut (
        .clk(clk), .rstb(rstb),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rd_valid(disp_rd_valid), .disp_rd_data(disp_rd_data),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rd_data(mem_q), .conflict_count(conflict_count)
    );

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(0), .CNT_W(16)) dut0 (
        .clk(clk), .rstb(rstb),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(d0_gnt),
        .disp_rd_valid(d0_rvalid_d), .disp_rd_data(d0_drdata),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(d0_ready), .cpu_rvalid(d0_rvalid_c), .cpu_rdata(d0_crdata),
        .mem_addr(d0_addr), .mem_we(d0_we), .mem_wdata(d0_wdata),
        .mem_rd_data(zero_rd), .conflict_count(d0_cc)
    );

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4), .CNT_W(4)) dut_s (
        .clk(clk), .rstb(rstb),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(ds_gnt),
        .disp_rd_valid(ds_rvalid_d), .disp_rd_data(ds_drdata),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(ds_ready), .cpu_rvalid(ds_rvalid_c), .cpu_rdata(ds_crdata),
        .mem_addr(ds_addr), .mem_we(ds_we), .mem_wdata(ds_wdata),
        .mem_rd_data(zero_rd), .conflict_count(ds_cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous VRAM model, 1-cycle read latency; fill loads mem[a] = a + 16
    logic fill;
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i + 16);
        end else if (mem_we) begin
            mem[mem_addr[9:0]] <= mem_wdata;
        end
        mem_q <= mem[mem_addr[9:0]];
    end

    typedef struct {
        logic          dreq;
        logic [AW-1:0] daddr;
        logic          cv;
        logic          cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          e_dg;
        logic          e_cr;
        logic          e_we;
        logic [AW-1:0] e_ma;
        logic [DW-1:0] e_wd;
        logic          e_drv;
        logic          e_crv;
        logic [DW-1:0] e_rd;
        logic [15:0]   e_cc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic dreq, input logic [AW-1:0] da,
                                input logic cv, input logic cwe, input logic [AW-1:0] ca,
                                input logic [DW-1:0] cwd, input logic dg, input logic cr,
                                input logic we, input logic [AW-1:0] ma, input logic [DW-1:0] wd,
                                input logic drv, input logic crv, input logic [DW-1:0] rd,
                                input logic [15:0] cc);
        vec_t v;
        v.dreq = dreq; v.daddr = da; v.cv = cv; v.cwe = cwe; v.caddr = ca; v.cwd = cwd;
        v.e_dg = dg; v.e_cr = cr; v.e_we = we; v.e_ma = ma; v.e_wd = wd;
        v.e_drv = drv; v.e_crv = crv; v.e_rd = rd; v.e_cc = cc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dreq, input logic [AW-1:0] da, input logic cv,
                         input logic cwe, input logic [AW-1:0] ca, input logic [DW-1:0] cwd);
        disp_req = dreq; disp_addr = da; cpu_valid = cv; cpu_we = cwe;
        cpu_addr = ca; cpu_wdata = cwd;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        rstb = 1'b0;
        @(posedge clk); #1;
        rstb = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        fill = 1'b1;
        rstb = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        #1 rstb = 1'b0;
        #2;
        chk("reset disp_rd_valid", 32'(disp_rd_valid), 32'd0);
        chk("reset cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("reset conflict_count", 32'(conflict_count), 32'd0);
        chk("reset mem_addr idle", 32'(mem_addr), 32'd0);
        @(posedge clk); #1;
        fill = 1'b0;
        rstb = 1'b1;

        // display-only stream, then idle drain
        for (int a = 0; a < 6; a++)
            vecs.push_back(mk(1, AW'(a), 0, 0, 0, 0, 1, 0, 0, AW'(a), 0,
                              a != 0, 0, 8'(a + 15), 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h15, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // CPU write then read of the same address
        vecs.push_back(mk(0, 0, 1, 1, 100, 8'hA5, 0, 1, 1, 100, 8'hA5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 100, 8'h00, 0, 1, 0, 100, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'hA5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // contention: display wins four cycles, CPU wins the fifth
        vecs.push_back(mk(1, 7, 1, 0, 200, 0, 1, 0, 0, 7, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 7, 1, 0, 200, 0, 1, 0, 0, 7, 0, 1, 0, 8'h17, 1));
        vecs.push_back(mk(1, 7, 1, 0, 200, 0, 1, 0, 0, 7, 0, 1, 0, 8'h17, 2));
        vecs.push_back(mk(1, 7, 1, 0, 200, 0, 1, 0, 0, 7, 0, 1, 0, 8'h17, 3));
        vecs.push_back(mk(1, 7, 1, 0, 200, 0, 0, 1, 0, 200, 0, 1, 0, 8'h17, 4));
        vecs.push_back(mk(1, 7, 0, 0, 0, 0, 1, 0, 0, 7, 0, 0, 1, 8'hD8, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h17, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive(vecs[i].dreq, vecs[i].daddr, vecs[i].cv, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd);
            #3;
            chk($sformatf("v%0d disp_gnt", i), 32'(disp_gnt), 32'(vecs[i].e_dg));
            chk($sformatf("v%0d cpu_ready", i), 32'(cpu_ready), 32'(vecs[i].e_cr));
            chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_ma));
            chk($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_wd));
            chk($sformatf("v%0d disp_rd_valid", i), 32'(disp_rd_valid), 32'(vecs[i].e_drv));
            chk($sformatf("v%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].e_crv));
            chk($sformatf("v%0d conflict_count", i), 32'(conflict_count), 32'(vecs[i].e_cc));
            if (vecs[i].e_drv)
                chk($sformatf("v%0d disp_rd_data", i), 32'(disp_rd_data), 32'(vecs[i].e_rd));
            if (vecs[i].e_crv)
                chk($sformatf("v%0d cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].e_rd));
        end

        // MAX_WAIT=0: CPU wins at once, display follows when CPU drops
        do_reset();
        @(posedge clk); #1;
        drive(1'b1, 17'd3, 1'b1, 1'b0, 17'd9, 8'h00);
        #3;
        chk("mw0 cpu_ready", 32'(d0_ready), 32'd1);
        chk("mw0 disp_gnt held", 32'(d0_gnt), 32'd0);
        chk("mw0 mem_addr cpu", 32'(d0_addr), 32'd9);
        chk("mw4 disp first", 32'(disp_gnt), 32'd1);
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        #3;
        chk("mw0 disp_gnt next", 32'(d0_gnt), 32'd1);
        chk("mw0 cpu_rvalid", 32'(d0_rvalid_c), 32'd1);
        chk("mw0 cpu_ready off", 32'(d0_ready), 32'd0);
        @(posedge clk); #1;
        disp_req = 1'b0;
        #3;
        chk("mw0 disp_rd_valid", 32'(d0_rvalid_d), 32'd1);
        chk("mw0 cpu_rvalid off", 32'(d0_rvalid_c), 32'd0);

        // asynchronous reset while a display read is in flight
        do_reset();
        @(posedge clk); #1;
        drive(1'b1, 17'd2, 1'b1, 1'b0, 17'd9, 8'h00);
        #3;
        chk("rst pre grant", 32'(disp_gnt), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        chk("rst pre drv", 32'(disp_rd_valid), 32'd1);
        chk("rst pre cc", 32'(conflict_count), 32'd1);
        rstb = 1'b0;
        #1;
        chk("rst async drv", 32'(disp_rd_valid), 32'd0);
        chk("rst async cc", 32'(conflict_count), 32'd0);
        disp_req = 1'b1;
        disp_addr = 17'd4;
        #1;
        chk("rst comb gnt", 32'(disp_gnt), 32'd1);
        @(posedge clk); #1;
        chk("rst held drv", 32'(disp_rd_valid), 32'd0);
        rstb = 1'b1;
        #3;
        chk("rst post gnt", 32'(disp_gnt), 32'd1);
        chk("rst post addr", 32'(mem_addr), 32'd4);
        @(posedge clk); #1;
        disp_req = 1'b0;
        #3;
        chk("rst post drv", 32'(disp_rd_valid), 32'd1);
        chk("rst post data", 32'(disp_rd_data), 32'h14);

        // 20 contention cycles: 4-bit counter saturates at 15
        do_reset();
        @(posedge clk); #1;
        drive(1'b1, 17'd1, 1'b1, 1'b0, 17'd2, 8'h00);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            chk($sformatf("sat k%0d", k), 32'(ds_cc), (k < 15) ? 32'(k) : 32'd15);
        end
        chk("sat wide cc", 32'(conflict_count), 32'd20);
        chk("sat mw0 cc", 32'(d0_cc), 32'd20);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
